// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - time-multiplexed seven-segment display scanner
//
// Purpose: scans DIGITS BCD digits onto one shared seven-segment bus, one
// digit per SCAN_DIV-cycle slot. All inputs are snapshotted once per frame,
// on the edge where the scan wraps back to digit 0, so a frame never tears.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   i_digits    4*DIGITS BCD digits, digit k at [4k+3:4k], digit 0 = LSD
//   i_dots      DIGITS decimal points, 1 = lit
//   o_segments  {g,f,e,d,c,b,a}, active-high, registered
//   o_dp        decimal point, active-high, registered
//   o_anodes    digit select, active-low, at most one bit low, registered
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 is never blanked).
module seg7_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic [0:0]          clk,
  input  logic [0:0]          rst,
  input  logic [4*DIGITS-1:0] i_digits,
  input  logic [DIGITS-1:0]   i_dots,
  output logic [6:0]          o_segments,
  output logic [0:0]          o_dp,
  output logic [DIGITS-1:0]   o_anodes
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] frame_digits;
  logic [DIGITS-1:0]   frame_dots;
  logic                tick;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          cur_digit;
  logic                cur_dot;
  logic                cur_blank;
  logic [6:0]          cur_segments;

  assign tick = (div == DIV_LAST);

  // Reset parks div and idx on their last values so the first cycle out of
  // reset is a tick that both takes the snapshot and wraps idx to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      div          <= DIV_LAST;
      idx          <= IDX_LAST;
      frame_digits <= '0;
      frame_dots   <= '0;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
      if (tick) begin
        if (idx == IDX_LAST) begin
          idx          <= '0;
          frame_digits <= i_digits;
          frame_dots   <= i_dots;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is blanked when it and everything above it in the frame is zero.
  always_comb begin
    blank = '0;
    blank[DIGITS-1] = (frame_digits[4*(DIGITS-1) +: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 1; k--) begin
      blank[k] = blank[k+1] && (frame_digits[4*k +: 4] == 4'd0);
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    cur_digit = '0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_digit = frame_digits[4*k +: 4];
        cur_dot   = frame_dots[k];
        cur_blank = blank[k];
      end
    end
  end

  always_comb begin
    cur_segments = 7'h40;
    case (cur_digit)
      4'd0:    cur_segments = 7'h3F;
      4'd1:    cur_segments = 7'h06;
      4'd2:    cur_segments = 7'h5B;
      4'd3:    cur_segments = 7'h4F;
      4'd4:    cur_segments = 7'h66;
      4'd5:    cur_segments = 7'h6D;
      4'd6:    cur_segments = 7'h7D;
      4'd7:    cur_segments = 7'h07;
      4'd8:    cur_segments = 7'h7F;
      4'd9:    cur_segments = 7'h6F;
      default: cur_segments = 7'h40;
    endcase
  end

  // One registered anode word per cycle: a digit change moves a single low
  // bit, so there is never an all-on intermediate state.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_anodes   <= '1;
      o_segments <= '0;
      o_dp       <= 1'b0;
    end else begin
      o_anodes   <= ~(DIGITS'(1) << idx);
      o_segments <= cur_blank ? 7'h00 : cur_segments;
      o_dp       <= cur_dot;
    end
  end

endmodule

// File: tb/tb_seg7_scanner.sv
// tb/tb_seg7_scanner.sv - directed and random bench for seg7_scanner
module tb_seg7_scanner;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_digits;
  logic [3:0]  i_dots;
  logic [6:0]  o_segments;
  logic        o_dp;
  logic [3:0]  o_anodes;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_digits  (i_digits),
    .i_dots    (i_dots),
    .o_segments(o_segments),
    .o_dp      (o_dp),
    .o_anodes  (o_anodes)
  );

  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0]      dots;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(string name, logic [3:0] exp_an, logic [6:0] exp_seg, logic exp_dp);
    n_vec++;
    if (o_anodes !== exp_an || o_segments !== exp_seg || o_dp !== exp_dp) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, o_anodes, o_segments, o_dp, exp_an, exp_seg, exp_dp);
    end
  endtask

  task automatic show(string name, int d, logic [6:0] seg, logic dp, int n);
    logic [3:0] an;
    an = 4'b0001 << d;
    an = ~an;
    for (int c = 0; c < n; c++) begin
      check($sformatf("%s d%0d c%0d", name, d, c), an, seg, dp);
      step();
    end
  endtask

  // Leaves the bench sampled just after the second edge following release,
  // i.e. at the first cycle digit 0 is displayed.
  task automatic start(logic [15:0] digits, logic [3:0] dots);
    rst      = 1'b1;
    i_digits = digits;
    i_dots   = dots;
    step();
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  initial begin
    int prev, cur, run;

    rst      = 1'b1;
    i_digits = '0;
    i_dots   = '0;
    step();
    step();
    check("reset", 4'b1111, 7'h00, 1'b0);

    vecs[0].digits = 16'h1234; vecs[0].dots = 4'b0000;
    vecs[0].seg    = {7'h06, 7'h5B, 7'h4F, 7'h66};
    vecs[1].digits = 16'hFA00; vecs[1].dots = 4'b0100;
    vecs[1].seg    = {7'h40, 7'h40, 7'h3F, 7'h3F};
    vecs[2].digits = 16'h0050; vecs[2].dots = 4'b0000;
    vecs[3].digits = 16'h0000; vecs[3].dots = 4'b0001;
    vecs[4].digits = 16'h9876; vecs[4].dots = 4'b1010;
    vecs[4].seg    = {7'h6F, 7'h7F, 7'h07, 7'h7D};
    vecs[5].digits = 16'h0B0C; vecs[5].dots = 4'b1001;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    vecs[2].seg    = {7'h00, 7'h00, 7'h6D, 7'h3F};
    vecs[3].seg    = {7'h00, 7'h00, 7'h00, 7'h3F};
    vecs[5].seg    = {7'h00, 7'h40, 7'h3F, 7'h40};
`else
    vecs[2].seg    = {7'h3F, 7'h3F, 7'h6D, 7'h3F};
    vecs[3].seg    = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    vecs[5].seg    = {7'h3F, 7'h40, 7'h3F, 7'h40};
`endif

    // Two full frames per vector: first frame and the wrap back to digit 0.
    for (int i = 0; i < 6; i++) begin
      start(vecs[i].digits, vecs[i].dots);
      for (int f = 0; f < 2; f++) begin
        for (int d = 0; d < DIGITS; d++) begin
          show($sformatf("vec%0d f%0d", i, f), d, vecs[i].seg[d], vecs[i].dots[d], SCAN_DIV);
        end
      end
    end

    // Input change while digit 1 is lit stays invisible until the next frame.
    start(16'h1234, 4'b0000);
    show("tear", 0, 7'h66, 1'b0, 4);
    show("tear", 1, 7'h4F, 1'b0, 1);
    i_digits = 16'h9999;
    show("tear", 1, 7'h4F, 1'b0, 3);
    show("tear", 2, 7'h5B, 1'b0, 4);
    show("tear", 3, 7'h06, 1'b0, 4);
    for (int d = 0; d < DIGITS; d++) show("tear_next", d, 7'h6F, 1'b0, 4);

    // One-cycle reset while digit 2 is showing.
    start(16'h1234, 4'b0000);
    show("rst_mid", 0, 7'h66, 1'b0, 4);
    show("rst_mid", 1, 7'h4F, 1'b0, 4);
    show("rst_mid", 2, 7'h5B, 1'b0, 2);
    rst = 1'b1;
    step();
    check("rst_mid_blank", 4'b1111, 7'h00, 1'b0);
    rst = 1'b0;
    step();
    step();
    show("rst_restart", 0, 7'h66, 1'b0, 4);
    show("rst_restart", 1, 7'h4F, 1'b0, 1);

    // Random inputs: single low anode, SCAN_DIV-long slots in order.
    start(16'($urandom), 4'($urandom));
    prev = 0;
    run  = 0;
    for (int c = 0; c < 1000 * DIGITS * SCAN_DIV; c++) begin
      n_vec++;
      if ($countones(~o_anodes) != 1) begin
        n_fail++;
        $display("FAIL rand_onehot cycle %0d: got an=%b, expected exactly one low bit", c, o_anodes);
      end
      cur = -1;
      for (int k = 0; k < DIGITS; k++) if (!o_anodes[k]) cur = k;
      if (cur == prev) begin
        run++;
      end else begin
        n_vec++;
        if (run != SCAN_DIV || cur != (prev + 1) % DIGITS) begin
          n_fail++;
          $display("FAIL rand_slot cycle %0d: got digit %0d after %0d cycles of digit %0d, expected digit %0d after %0d",
                   c, cur, run, prev, (prev + 1) % DIGITS, SCAN_DIV);
        end
        prev = cur;
        run  = 1;
      end
      i_digits = 16'($urandom);
      i_dots   = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
